uart_core: RTL and testbench

Parametrised single-clock UART combining transmitter, oversampling receiver and receive FIFO. It is the next-generation replacement for the split Tx/Rx pair. It runs both directions from one system clock, with programmable word width, stop bits, receive buffering and error reporting. It sits between a host register interface and the serial pins.

---
 rtl/uart_core.sv | 175 +++++++++++++++++
 tb/tb_uart_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: single-clock UART with TX, 16x oversampling RX and FWFT receive FIFO.
// Optional parity bit on both directions when UART_PARITY_EN is defined.
module uart_core #(
   parameter int DATA_W     = 8,
   parameter int OSR_DIV    = 27,
   parameter int STOP_BITS  = 1,
   parameter int RX_DEPTH   = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_tx,
   input  logic              write_tx,
   output logic              ready_tx,
   output logic              txd,
   input  logic              rxd,
   output logic [DATA_W-1:0] data_rx,
   output logic              ready_rx,
   input  logic              read_rx,
   output logic              overrun_rx,
   output logic              frame_err_rx,
   output logic              parity_err_rx,
   input  logic              clear_err
);
`ifdef UART_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int BIT = 16 * OSR_DIV;
   localparam int CW  = $clog2(STOP_BITS * BIT + 1);
   localparam int AW  = $clog2(RX_DEPTH);
   localparam logic [CW-1:0] BIT_END  = CW'(BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(BIT / 2 - 1);
   localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * BIT - 1);
   localparam logic [3:0]    LAST     = 4'(DATA_W - 1);
   localparam bit            ODD      = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t            tx_st, rx_st;
   logic [CW-1:0]     tx_cnt, rx_cnt;
   logic [DATA_W-1:0] tx_sh, rx_sh;
   logic [3:0]        tx_bit, rx_bit;
   logic              tx_par, rx_par, rx_s1, rxd_s, armed;
   logic [DATA_W-1:0] mem [RX_DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [AW:0]       cnt;
   logic              stop_smp, par_bad, push, pop, full, wr;
   logic              ovr_flag, frm_flag, par_flag;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         tx_st    <= IDLE;
         txd      <= 1'b1;
         ready_tx <= 1'b1;
         tx_cnt   <= '0;
         tx_sh    <= '0;
         tx_bit   <= '0;
         tx_par   <= 1'b0;
      end else if (tx_st == IDLE) begin
         if (write_tx) begin
            tx_st    <= START;
            txd      <= 1'b0;
            ready_tx <= 1'b0;
            tx_cnt   <= '0;
            tx_sh    <= data_tx;
            tx_par   <= ^data_tx ^ ODD;
         end
      end else if (tx_cnt != (tx_st == STOP ? STOP_END : BIT_END)) begin
         tx_cnt <= tx_cnt + 1'b1;
      end else begin
         tx_cnt <= '0;
         tx_sh  <= tx_sh >> 1;
         case (tx_st)
            START: begin
               tx_st  <= DATA;
               txd    <= tx_sh[0];
               tx_bit <= '0;
            end
            DATA: begin
               txd    <= tx_bit == LAST ? (PAR_EN ? tx_par : 1'b1) : tx_sh[0];
               tx_st  <= tx_bit == LAST ? (PAR_EN ? PAR : STOP) : DATA;
               tx_bit <= tx_bit + 1'b1;
            end
            PAR: begin
               tx_st <= STOP;
               txd   <= 1'b1;
            end
            default: begin
               tx_st    <= IDLE;
               ready_tx <= 1'b1;
            end
         endcase
      end

   // armed only re-asserts once the line has been seen high, so a held break cannot retrigger
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rx_s1  <= 1'b1;
         rxd_s  <= 1'b1;
         rx_st  <= IDLE;
         armed  <= 1'b0;
         rx_cnt <= '0;
         rx_sh  <= '0;
         rx_bit <= '0;
         rx_par <= 1'b0;
      end else begin
         rx_s1 <= rxd;
         rxd_s <= rx_s1;
         if (rx_st == IDLE) begin
            if (armed && !rxd_s) begin
               rx_st  <= START;
               rx_cnt <= '0;
               armed  <= 1'b0;
            end else begin
               armed <= armed | rxd_s;
            end
         end else if (rx_cnt != (rx_st == START ? HALF_END : BIT_END)) begin
            rx_cnt <= rx_cnt + 1'b1;
         end else begin
            rx_cnt <= '0;
            case (rx_st)
               START: begin
                  rx_st  <= rxd_s ? IDLE : DATA;
                  rx_bit <= '0;
               end
               DATA: begin
                  rx_sh  <= {rxd_s, rx_sh[DATA_W-1:1]};
                  rx_bit <= rx_bit + 1'b1;
                  rx_st  <= rx_bit == LAST ? (PAR_EN ? PAR : STOP) : DATA;
               end
               PAR: begin
                  rx_par <= rxd_s;
                  rx_st  <= STOP;
               end
               default: rx_st <= IDLE;
            endcase
         end
      end

   assign stop_smp = rx_st == STOP && rx_cnt == BIT_END;
   assign par_bad  = PAR_EN && ((^rx_sh ^ rx_par) != ODD);
   assign push     = stop_smp && rxd_s && !par_bad;
   assign full     = cnt == (AW+1)'(RX_DEPTH);
   assign pop      = read_rx && cnt != '0;
   assign wr       = push && (!full || pop);

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
         wp       <= '0;
         rp       <= '0;
         cnt      <= '0;
         ovr_flag <= 1'b0;
         frm_flag <= 1'b0;
         par_flag <= 1'b0;
      end else begin
         if (wr) begin
            mem[wp] <= rx_sh;
            wp      <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         cnt      <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
         ovr_flag <= (push && full && !pop) | (ovr_flag & ~clear_err);
         frm_flag <= (stop_smp && !rxd_s) | (frm_flag & ~clear_err);
         par_flag <= (stop_smp && rxd_s && par_bad) | (par_flag & ~clear_err);
      end

   assign data_rx       = mem[rp];
   assign ready_rx      = cnt != '0;
   assign overrun_rx    = ovr_flag;
   assign frame_err_rx  = frm_flag;
   assign parity_err_rx = PAR_EN & par_flag;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven and scoreboard bench for uart_core (DATA_W=8, OSR_DIV=4).
// Parity checks are compiled in when UART_PARITY_EN is defined.
module tb_uart_core;
   localparam int BIT = 64;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       push;
      logic       ferr;
   } vec_t;

   logic       clk = 0, rst = 0, write_tx = 0, read_rx = 0, clear_err = 0;
   logic       rxd_drv = 1, loop = 0;
   logic [7:0] data_tx = 0;
   logic       ready_tx, txd, rxd, ready_rx, overrun_rx, frame_err_rx, parity_err_rx;
   logic [7:0] data_rx;
   int         total = 0, bad = 0;
   logic [7:0] exp_q[$];
   vec_t       tbl[6];

   assign rxd = loop ? txd : rxd_drv;
   always #5 clk = ~clk;

   uart_core #(.DATA_W(8), .OSR_DIV(4), .STOP_BITS(1), .RX_DEPTH(4), .PARITY_ODD(0)) dut (
      .clk(clk), .rst(rst), .data_tx(data_tx), .write_tx(write_tx), .ready_tx(ready_tx),
      .txd(txd), .rxd(rxd), .data_rx(data_rx), .ready_rx(ready_rx), .read_rx(read_rx),
      .overrun_rx(overrun_rx), .frame_err_rx(frame_err_rx), .parity_err_rx(parity_err_rx),
      .clear_err(clear_err)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic rd();
      read_rx = 1;
      @(negedge clk);
      read_rx = 0;
   endtask

   task automatic clr();
      clear_err = 1;
      @(negedge clk);
      clear_err = 0;
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop);
      rxd_drv = 0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = d[i];
         repeat (BIT) @(negedge clk);
      end
      if (P == 1) begin
         rxd_drv = par;
         repeat (BIT) @(negedge clk);
      end
      rxd_drv = stop;
      repeat (BIT) @(negedge clk);
      rxd_drv = 1;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      int n = 0;
      while (!ready_tx && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("tx_ready_wait", 16'(ready_tx), 16'd1);
      data_tx  = d;
      write_tx = 1;
      @(negedge clk);
      write_tx = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      tbl = '{'{8'h00, 1'b1, 1'b1, 1'b0}, '{8'hFF, 1'b1, 1'b1, 1'b0},
              '{8'h3C, 1'b0, 1'b0, 1'b1}, '{8'h81, 1'b1, 1'b1, 1'b0},
              '{8'h5A, 1'b1, 1'b1, 1'b0}, '{8'hC3, 1'b0, 1'b0, 1'b1}};
      repeat (3) @(negedge clk);
      chk("rst_txd", 16'(txd), 16'd1);
      chk("rst_ready_tx", 16'(ready_tx), 16'd1);
      chk("rst_ready_rx", 16'(ready_rx), 16'd0);
      chk("rst_data_rx", 16'(data_rx), 16'h00);
      chk("rst_flags", {13'd0, overrun_rx, frame_err_rx, parity_err_rx}, 16'd0);
      rst = 1;
      repeat (4) @(negedge clk);

      // loopback with exact cycle checkpoints relative to the accepting cycle t
      loop = 1;
      exp_q.push_back(8'hA5);
      data_tx  = 8'hA5;
      write_tx = 1;
      @(negedge clk);
      write_tx = 0;
      for (int k = 1; k <= 760; k++) begin
         if (k == 1) begin
            chk("lb_txd_t1", 16'(txd), 16'd0);
            chk("lb_busy_t1", 16'(ready_tx), 16'd0);
         end
         if (k == 64) chk("lb_txd_t64", 16'(txd), 16'd0);
         if (k == 65) chk("lb_bit0", 16'(txd), 16'd1);
         if (k == 611 + 64 * P) chk("lb_rx_early", 16'(ready_rx), 16'd0);
         if (k == 612 + 64 * P) begin
            chk("lb_rx_rise", 16'(ready_rx), 16'd1);
            chk("lb_rx_data", 16'(data_rx), 16'(exp_q.pop_front()));
         end
         if (k == 640 + 64 * P) chk("lb_busy_end", 16'(ready_tx), 16'd0);
         if (k == 641 + 64 * P) chk("lb_ready_tx", 16'(ready_tx), 16'd1);
         @(negedge clk);
      end
      rd();
      chk("lb_popped", 16'(ready_rx), 16'd0);

      // second write pulsed while busy must be ignored
      exp_q.push_back(8'h00);
      send(8'h00);
      repeat (100) @(negedge clk);
      data_tx  = 8'hFF;
      write_tx = 1;
      @(negedge clk);
      write_tx = 0;
      chk("b2b_busy", 16'(ready_tx), 16'd0);
      exp_q.push_back(8'hFF);
      send(8'hFF);
      repeat ((10 + P) * BIT + 100) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("b2b_ready", 16'(ready_rx), 16'd1);
         chk("b2b_data", 16'(data_rx), 16'(exp_q.pop_front()));
         rd();
      end
      chk("b2b_empty", 16'(ready_rx), 16'd0);
      loop = 0;
      repeat (BIT) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         if (tbl[i].push) exp_q.push_back(tbl[i].d);
         rx_frame(tbl[i].d, ^tbl[i].d, tbl[i].stop);
         chk("tbl_ready_rx", 16'(ready_rx), 16'(tbl[i].push));
         chk("tbl_frame_err", 16'(frame_err_rx), 16'(tbl[i].ferr));
         if (tbl[i].push) begin
            chk("tbl_data", 16'(data_rx), 16'(exp_q.pop_front()));
            rd();
         end
         clr();
      end

      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(8'h10 + 8'(i));
         rx_frame(8'h10 + 8'(i), ^(8'h10 + 8'(i)), 1'b1);
      end
      chk("ovr_flag", 16'(overrun_rx), 16'd1);
      for (int i = 0; i < 4; i++) begin
         chk("ovr_ready", 16'(ready_rx), 16'd1);
         chk("ovr_data", 16'(data_rx), 16'(exp_q.pop_front()));
         rd();
      end
      chk("ovr_empty", 16'(ready_rx), 16'd0);
      clr();
      chk("ovr_cleared", 16'(overrun_rx), 16'd0);

      // held break: one frame error, then no retrigger until the line returns high
      rxd_drv = 0;
      repeat (700) @(negedge clk);
      chk("brk_ferr", 16'(frame_err_rx), 16'd1);
      chk("brk_no_push", 16'(ready_rx), 16'd0);
      clr();
      repeat (1220) @(negedge clk);
      chk("brk_no_retrig", 16'(frame_err_rx), 16'd0);
      rxd_drv = 1;
      repeat (BIT) @(negedge clk);

      rxd_drv = 0;
      repeat (12) @(negedge clk);
      rxd_drv = 1;
      repeat (1000) @(negedge clk);
      chk("glitch_no_push", 16'(ready_rx), 16'd0);
      chk("glitch_no_ferr", 16'(frame_err_rx), 16'd0);
      exp_q.push_back(8'h96);
      rx_frame(8'h96, ^8'h96, 1'b1);
      chk("glitch_next_ready", 16'(ready_rx), 16'd1);
      chk("glitch_next_data", 16'(data_rx), 16'(exp_q.pop_front()));
      rd();

`ifdef UART_PARITY_EN
      rx_frame(8'h07, 1'b0, 1'b1);
      chk("par_err", 16'(parity_err_rx), 16'd1);
      chk("par_discard", 16'(ready_rx), 16'd0);
      clr();
      exp_q.push_back(8'h07);
      rx_frame(8'h07, 1'b1, 1'b1);
      chk("par_ok_flag", 16'(parity_err_rx), 16'd0);
      chk("par_ok_data", 16'(data_rx), 16'(exp_q.pop_front()));
      rd();
`else
      chk("par_tied", 16'(parity_err_rx), 16'd0);
`endif

      loop = 1;
      send(8'h55);
      repeat (100) @(negedge clk);
      chk("mid_busy", 16'(ready_tx), 16'd0);
      rst = 0;
      #1;
      chk("mid_rst_txd", 16'(txd), 16'd1);
      chk("mid_rst_ready_tx", 16'(ready_tx), 16'd1);
      chk("mid_rst_ready_rx", 16'(ready_rx), 16'd0);
      @(negedge clk);
      rst = 1;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
